// File: rtl/cdc_importer_fifo.sv
// Destination side of a toggle req/ack CDC handshake with an elastic buffer.
// A change on cdc_req (after synchronisation) captures cdc_data into a small
// FIFO and answers with cdc_ack. The buffered words are presented locally as
// a first-word-fall-through valid/ready stream. While the buffer is full, ack
// is withheld, so the remote source stalls instead of overrunning the buffer.
module cdc_importer_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cdc_req,
  input  logic [WIDTH-1:0]           cdc_data,
  output logic                       cdc_ack,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   pending;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [WIDTH-1:0]       mem [DEPTH];

  // Synchroniser chain for the request toggle; only the last stage is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], cdc_req};
    end
  end

  assign req_s   = req_sync[SYNC_STAGES-1];
  assign pending = (req_s != cdc_ack);
  // Fullness is judged on the current level, so a same-cycle pop never
  // makes room for a push; the push simply happens one cycle later.
  assign full    = (level == LW'(DEPTH));
  assign push    = pending && !full;
  assign pop     = out_valid && out_ready;

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  // Buffer storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cdc_data;
    end
  end

  // Pointers, ack and level. Ack is registered, so pending drops on the
  // cycle after a capture and one toggle yields exactly one word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cdc_ack <= 1'b0;
      level   <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        cdc_ack <= req_s;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_importer_fifo.sv
// Directed bench for cdc_importer_fifo with default parameters
// (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
module tb_cdc_importer_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       cdc_req;
  logic [7:0] cdc_data;
  logic       cdc_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;

  cdc_importer_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .cdc_req   (cdc_req),
    .cdc_data  (cdc_data),
    .cdc_ack   (cdc_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source side: present data, toggle req, wait (bounded) for the ack.
  task automatic send_word(input logic [7:0] d);
    cdc_data = d;
    cdc_req  = ~cdc_req;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (cdc_ack == cdc_req) break;
    end
    chk("send_ack", {31'd0, cdc_ack}, {31'd0, cdc_req});
  endtask

  logic [15:0] rdy_pat;
  logic [7:0]  exp_word;
  int          sent;
  int          got;

  initial begin
    rst       = 1'b1;
    cdc_req   = 1'b0;
    cdc_data  = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle_ack",   {31'd0, cdc_ack},   32'd0);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_level", {29'd0, level},     32'd0);
      tick();
    end

    // 2: single word latency and pop
    out_ready = 1'b1;
    cdc_data  = 8'hA5;
    cdc_req   = 1'b1;
    tick();
    chk("lat_ack_e1", {31'd0, cdc_ack}, 32'd0);
    tick();
    chk("lat_ack_e2",   {31'd0, cdc_ack},   32'd0);
    chk("lat_valid_e2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_ack_e3",   {31'd0, cdc_ack},   32'd1);
    chk("lat_valid_e3", {31'd0, out_valid}, 32'd1);
    chk("lat_data_e3",  {24'd0, out_data},  32'hA5);
    tick();
    chk("lat_popped_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_popped_level", {29'd0, level},     32'd0);
    tick();
    chk("lat_no_dup", {29'd0, level}, 32'd0);

    // 3/4: fill to DEPTH, stall 5th word, pop-without-push when full
    out_ready = 1'b0;
    send_word(8'h01);
    chk("fill_l1", {29'd0, level}, 32'd1);
    send_word(8'h02);
    send_word(8'h03);
    send_word(8'h04);
    chk("fill_l4",   {29'd0, level},    32'd4);
    chk("fill_head", {24'd0, out_data}, 32'h01);
    cdc_data = 8'h05;
    cdc_req  = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("full_ack_held", {31'd0, cdc_ack}, 32'd1);
    chk("full_level",    {29'd0, level},   32'd4);
    out_ready = 1'b1;
    chk("full_head", {24'd0, out_data}, 32'h01);
    tick();
    out_ready = 1'b0;
    chk("full_pop_level", {29'd0, level},    32'd3);
    chk("full_pop_ack",   {31'd0, cdc_ack},  32'd1);
    chk("full_pop_head",  {24'd0, out_data}, 32'h02);
    tick();
    chk("refill_level", {29'd0, level},   32'd4);
    chk("refill_ack",   {31'd0, cdc_ack}, 32'd0);
    out_ready = 1'b1;
    exp_word  = 8'h02;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_data",  {24'd0, out_data},  {24'd0, exp_word});
      exp_word = exp_word + 8'd1;
      tick();
    end
    chk("drain_level", {29'd0, level},     32'd0);
    chk("drain_valid_end", {31'd0, out_valid}, 32'd0);

    // 5: streaming with irregular consumer
    rdy_pat  = 16'b1011_0010_1101_0110;
    sent     = 0;
    got      = 0;
    exp_word = 8'h30;
    for (int i = 0; i < 300; i++) begin
      if (got == 10) break;
      out_ready = rdy_pat[i % 16];
      if (out_valid && out_ready) begin
        chk("stream_data", {24'd0, out_data}, {24'd0, exp_word});
        exp_word = exp_word + 8'd1;
        got++;
      end
      if ((cdc_ack == cdc_req) && (sent < 10)) begin
        cdc_data = 8'h30 + 8'(sent);
        cdc_req  = ~cdc_req;
        sent++;
      end
      tick();
    end
    chk("stream_got",   got, 32'd10);
    chk("stream_level", {29'd0, level}, 32'd0);

    // 6: reset mid-operation with req still high
    out_ready = 1'b0;
    send_word(8'h41);
    send_word(8'h42);
    send_word(8'h43);
    chk("pre_rst_level", {29'd0, level},   32'd3);
    chk("pre_rst_ack",   {31'd0, cdc_ack}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_level", {29'd0, level},     32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ack",   {31'd0, cdc_ack},   32'd0);
    tick();
    tick();
    chk("post_rst_e2_ack", {31'd0, cdc_ack}, 32'd0);
    tick();
    chk("post_rst_e3_ack",   {31'd0, cdc_ack},  32'd1);
    chk("post_rst_e3_level", {29'd0, level},    32'd1);
    chk("post_rst_e3_data",  {24'd0, out_data}, 32'h43);
    tick();
    tick();
    chk("post_rst_single", {29'd0, level}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
